// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin data-selector arbiter.
// State encodings, requester count and one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [1:0] idx
  );
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_picker.sv
// Cyclic first-set-bit search over the request vector,
// starting at the rotation pointer.
module rr_picker
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             any,
  output logic [1:0]       winner
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  always_comb begin
    dbl    = {req, req};
    rot    = dbl[ptr +: N_REQ];
    any    = |req;
    winner = ptr;
    // descending scan so the nearest set bit to ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        winner = ptr + k[1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner sequencer for the shared 4-way byte selector.
// Grants one owner, bounds its hold time, inserts a gap cycle.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             any;
  logic [1:0]       winner;
  logic             rel;

  rr_picker u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign rel = !req[sel] || (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      sel        <= '0;
      ptr        <= '0;
      cnt        <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_GAP: begin
          if (any) begin
            state      <= ST_GRANT;
            grant      <= onehot(winner);
            sel        <= winner;
            cnt        <= '0;
            data_valid <= 1'b1;
            busy       <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          // cnt never passes LAST: reaching it forces release
          if (rel) begin
            state      <= ST_GAP;
            grant      <= '0;
            data_valid <= 1'b0;
            ptr        <= sel + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          grant      <= '0;
          data_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (data_valid) begin
      unique case (sel)
        2'd0: data_out = d0;
        2'd1: data_out = d1;
        2'd2: data_out = d2;
        default: data_out = d3;
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4-way, 8-bit data selector. Up to four requesters each present a request and a data byte. The block grants exactly one owner at a time, drives the 2-bit select, and presents the selected byte with a valid flag. Ownership lasts until the owner drops its request or a hold limit expires, so no requester can monopolise the shared output (display/LED/bus path).

Parameters:
DATA_W, 8, width of each data input and of data_out
MAX_HOLD, 16, maximum consecutive valid cycles per grant; legal range 1..255
CNT_W, $clog2(MAX_HOLD) (minimum 1), hold counter width; derived, do not override

Ports:
clock  in  1  rising-edge system clock
reset  in  1  asynchronous, active-low reset
req  in  4  level request, bit i = requester i
d0  in  DATA_W  data from requester 0
d1  in  DATA_W  data from requester 1
d2  in  DATA_W  data from requester 2
d3  in  DATA_W  data from requester 3
grant  out  4  one-hot current owner; 0 when none
sel  out  2  select index of current/last owner
data_out  out  DATA_W  selected data; 0 when data_valid=0
data_valid  out  1  high while state=GRANT
busy  out  1  high when state != IDLE

Behaviour:
- One clock. Reset is asynchronous and active-low: reset=0 clears all state immediately, independent of clock.
- Reset values: state=IDLE, grant=0, sel=0, data_valid=0, data_out=0, busy=0, rotation pointer ptr=0, hold counter=0.
- States: IDLE, GRANT, GAP.
- IDLE: if req!=0, pick the first set bit scanning cyclically from ptr (ptr, ptr+1, ... mod 4). On the next edge: GRANT, grant=one-hot(winner), sel=winner, counter=0. Latency from req sampled high to data_valid high is 1 cycle. If req=0, remain in IDLE.
- GRANT:
  - data_out = d[sel] (combinational from the registered sel), data_valid=1.
  - Counter increments every cycle.
  - Release condition: req[owner]==0 sampled, OR counter==MAX_HOLD-1 (owner has had MAX_HOLD valid cycles).
  - On release, at the next edge: state=GAP, grant=0, data_valid=0, sel unchanged, ptr=(owner+1) mod 4.
- GAP: exactly one turnaround cycle with data_valid=0. Arbitrate with the same rule as IDLE:
  - req!=0: go to GRANT with the new winner.
  - req=0: go to IDLE.
- Non-owner requests during GRANT never preempt. They wait until release.
- Timeout while the owner still requests: the owner drops to lowest priority. If it is the only requester, it is re-granted after the GAP cycle.
- A request that rises and falls while another requester owns the block is lost; requesters must hold req until granted.
- Simultaneous owner-drop and timeout: treated as a single release, same behaviour.
- MAX_HOLD=1: every grant lasts exactly 1 valid cycle.
- Reset asserted mid-GRANT: outputs clear asynchronously, ptr returns to 0, and the next grant after reset release follows IDLE rules.
- Hold counter saturates and never wraps inside GRANT; it clears on every entry to GRANT.
- busy=1 in GRANT and GAP.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
  - requester count constant N_REQ=4
- One combinational sub-module, rr_picker. Inputs: req[3:0], ptr[1:0]. Outputs: any, winner[1:0].
- The FSM, counter, pointer and output data selection live in mux_rr_arbiter.

Test Plan:
1. reset=0 with req=4'b1111 and clock running -> grant=0, sel=0, data_valid=0, data_out=0. Release reset -> first edge gives grant=4'b0001, sel=0.
2. MAX_HOLD=16, d2=8'hA5, only req[2] high for 3 cycles then low -> grant=4'b0100 one cycle after req rises; data_out=8'hA5 with data_valid for 3 cycles; one GAP cycle; then IDLE with busy=0.
3. MAX_HOLD=4, req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order; each has 4 valid cycles followed by 1 GAP cycle (period 5 cycles per owner).
4. MAX_HOLD=4, only req[1] held -> repeating pattern of 4 valid cycles, 1 GAP cycle, re-grant 0010; data_out=d1 each valid cycle.
5. Requester 1 owns; req[0] rises mid-grant -> no preemption. After req[1] drops, GAP, then grant=0001. Requester 3 owns and drops with req[0] and req[2] both high -> ptr=0, so grant=0001.
6. reset pulsed low mid-GRANT between clock edges -> grant, data_valid, data_out go 0 without a clock edge. After release with req=4'b0100 -> grant=0100 on the next edge (ptr reset to 0, no stale owner).
